hazard_ctrl_pipe: RTL and testbench

HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/fwd_unit.sv | 23 ++
 rtl/hazard_ctrl_pipe.sv | 119 +++++++++++
 tb/tb_hazard_ctrl_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and stage-control type for the pipeline control path.
// Pure declarations; no latency or flow control of its own.
package pipe_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_SEXT = 2'b01;
    localparam logic [1:0] ALUB_ZEXT = 2'b10;
    localparam logic [1:0] ALUB_FOUR = 2'b11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] alusrcb;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
    } stage_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// ALU operand bypass select for one source register; combinational, 0 cycles.
// No flow control: MEM result outranks WB because it is the younger write.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_dst,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_dst,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_dst != 5'd0) && (mem_dst == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_dst != 5'd0) && (wb_dst == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall and forwarding; ID->EX/MEM/WB = 1/2/3 cycles.
// Backpressure: stall freezes PC and IF/ID upstream for one cycle while a bubble enters EX; flush overrides stall.
module hazard_ctrl_pipe
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_regdst,
    input  logic       id_memread,
    input  logic       id_memwrite,
    input  logic       id_regwrite,
    input  logic       id_memtoreg,
    input  logic [1:0] id_aluop,
    input  logic [1:0] id_alusrcb,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       flush,
    output logic [1:0] ex_aluop,
    output logic [1:0] ex_alusrcb,
    output logic [4:0] ex_rs,
    output logic [4:0] ex_rt,
    output logic [4:0] ex_dst,
    output logic       mem_memread,
    output logic       mem_memwrite,
    output logic [4:0] mem_dst,
    output logic [4:0] wb_dst,
    output logic       wb_regwrite,
    output logic       wb_memtoreg,
    output logic       stall,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    stage_ctrl_t ex_ctrl;
    stage_ctrl_t id_ctrl;
    logic [4:0]  id_dst;
    logic        uses_rt;
    logic        bubble;
    logic        mem_regwrite;
    logic        mem_memtoreg;

    assign id_dst  = id_regdst ? id_rd : id_rt;
    assign uses_rt = id_regdst | id_memwrite;

    // Writes to r0 are architecturally dropped, so never advertise them for forwarding.
    always_comb begin
        id_ctrl          = '0;
        id_ctrl.aluop    = id_aluop;
        id_ctrl.alusrcb  = id_alusrcb;
        id_ctrl.memread  = id_memread;
        id_ctrl.memwrite = id_memwrite;
        id_ctrl.regwrite = id_regwrite && (id_dst != 5'd0);
        id_ctrl.memtoreg = id_memtoreg;
    end

    assign stall = ex_ctrl.memread && (ex_dst != 5'd0) && !flush &&
                   ((ex_dst == id_rs) || (uses_rt && (ex_dst == id_rt)));
    assign bubble = stall | flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl      <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_dst       <= '0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_dst      <= '0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_dst       <= '0;
        end else begin
            if (bubble) begin
                ex_ctrl <= '0;
                ex_rs   <= '0;
                ex_rt   <= '0;
                ex_dst  <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_rs   <= id_rs;
                ex_rt   <= id_rt;
                ex_dst  <= id_dst;
            end
            mem_memread  <= ex_ctrl.memread;
            mem_memwrite <= ex_ctrl.memwrite;
            mem_regwrite <= ex_ctrl.regwrite;
            mem_memtoreg <= ex_ctrl.memtoreg;
            mem_dst      <= ex_dst;
            wb_regwrite  <= mem_regwrite;
            wb_memtoreg  <= mem_memtoreg;
            wb_dst       <= mem_dst;
        end
    end

    assign ex_aluop   = ex_ctrl.aluop;
    assign ex_alusrcb = ex_ctrl.alusrcb;

    fwd_unit u_fwd_a (
        .src          (ex_rs),
        .mem_regwrite (mem_regwrite),
        .mem_dst      (mem_dst),
        .wb_regwrite  (wb_regwrite),
        .wb_dst       (wb_dst),
        .sel          (fwd_a)
    );

    fwd_unit u_fwd_b (
        .src          (ex_rt),
        .mem_regwrite (mem_regwrite),
        .mem_dst      (mem_dst),
        .wb_regwrite  (wb_regwrite),
        .wb_dst       (wb_dst),
        .sel          (fwd_b)
    );

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: instruction-stream table plus flush and reset sequences.
module tb_hazard_ctrl_pipe;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_R   = 3'd1;
    localparam logic [2:0] C_LW  = 3'd2;
    localparam logic [2:0] C_SW  = 3'd3;
    localparam logic [2:0] C_ORI = 3'd4;

    logic       clk;
    logic       rst;
    logic       id_regdst, id_memread, id_memwrite, id_regwrite, id_memtoreg;
    logic [1:0] id_aluop, id_alusrcb;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       flush;
    logic [1:0] ex_aluop, ex_alusrcb;
    logic [4:0] ex_rs, ex_rt, ex_dst;
    logic       mem_memread, mem_memwrite;
    logic [4:0] mem_dst, wb_dst;
    logic       wb_regwrite, wb_memtoreg;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .id_regdst    (id_regdst),
        .id_memread   (id_memread),
        .id_memwrite  (id_memwrite),
        .id_regwrite  (id_regwrite),
        .id_memtoreg  (id_memtoreg),
        .id_aluop     (id_aluop),
        .id_alusrcb   (id_alusrcb),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .flush        (flush),
        .ex_aluop     (ex_aluop),
        .ex_alusrcb   (ex_alusrcb),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dst       (ex_dst),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .mem_dst      (mem_dst),
        .wb_dst       (wb_dst),
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg),
        .stall        (stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cls;
        logic [4:0] rs, rt, rd;
        logic       e_stall;
        logic [1:0] e_fwd_a, e_fwd_b, e_ex_aluop;
        logic [4:0] e_ex_dst;
        logic       e_mem_memread;
        logic [4:0] e_mem_dst;
        logic       e_wb_regwrite;
        logic [4:0] e_wb_dst;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic [2:0] c, input int rs, input int rt, input int rd,
                                input int st, input int fa, input int fb, input int ea,
                                input int ed, input int mm, input int md, input int wr,
                                input int wd);
        vec_t v;
        v.cls = c;
        v.rs = rs[4:0]; v.rt = rt[4:0]; v.rd = rd[4:0];
        v.e_stall = st[0]; v.e_fwd_a = fa[1:0]; v.e_fwd_b = fb[1:0];
        v.e_ex_aluop = ea[1:0]; v.e_ex_dst = ed[4:0];
        v.e_mem_memread = mm[0]; v.e_mem_dst = md[4:0];
        v.e_wb_regwrite = wr[0]; v.e_wb_dst = wd[4:0];
        return v;
    endfunction

    task automatic drive(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic fl);
        {id_regdst, id_memread, id_memwrite, id_regwrite, id_memtoreg} = 5'b0;
        id_aluop   = 2'b00;
        id_alusrcb = 2'b00;
        case (c)
            C_R:   begin id_regdst = 1'b1; id_regwrite = 1'b1; id_aluop = 2'b10; end
            C_LW:  begin id_memread = 1'b1; id_regwrite = 1'b1; id_memtoreg = 1'b1; id_alusrcb = 2'b01; end
            C_SW:  begin id_memwrite = 1'b1; id_alusrcb = 2'b01; end
            C_ORI: begin id_regwrite = 1'b1; id_aluop = 2'b11; id_alusrcb = 2'b10; end
            default: ;
        endcase
        id_rs = rs;
        id_rt = rt;
        id_rd = rd;
        flush = fl;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ex_aluop"},     32'(ex_aluop), 0);
        chk({tag, " ex_alusrcb"},   32'(ex_alusrcb), 0);
        chk({tag, " ex_rs"},        32'(ex_rs), 0);
        chk({tag, " ex_rt"},        32'(ex_rt), 0);
        chk({tag, " ex_dst"},       32'(ex_dst), 0);
        chk({tag, " mem_memread"},  32'(mem_memread), 0);
        chk({tag, " mem_memwrite"}, 32'(mem_memwrite), 0);
        chk({tag, " mem_dst"},      32'(mem_dst), 0);
        chk({tag, " wb_dst"},       32'(wb_dst), 0);
        chk({tag, " wb_regwrite"},  32'(wb_regwrite), 0);
        chk({tag, " wb_memtoreg"},  32'(wb_memtoreg), 0);
        chk({tag, " stall"},        32'(stall), 0);
        chk({tag, " fwd_a"},        32'(fwd_a), 0);
        chk({tag, " fwd_b"},        32'(fwd_b), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: class rs rt rd | stall fwd_a fwd_b | ex_aluop ex_dst mem_memread mem_dst wb_regwrite wb_dst
        tbl[0]  = mk(C_LW,  1, 5, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(C_R,   5, 2, 6,  1, 0, 0,  0, 5, 0, 0, 0, 0);
        tbl[2]  = mk(C_R,   5, 2, 6,  0, 0, 0,  0, 0, 1, 5, 0, 0);
        tbl[3]  = mk(C_R,   6, 6, 3,  0, 1, 0,  2, 6, 0, 0, 1, 5);
        tbl[4]  = mk(C_R,   3, 3, 4,  0, 2, 2,  2, 3, 0, 6, 0, 0);
        tbl[5]  = mk(C_ORI, 0, 4, 0,  0, 2, 2,  2, 4, 0, 3, 1, 6);
        tbl[6]  = mk(C_R,   4, 4, 7,  0, 0, 2,  3, 4, 0, 4, 1, 3);
        tbl[7]  = mk(C_LW,  0, 0, 0,  0, 2, 2,  2, 7, 0, 4, 1, 4);
        tbl[8]  = mk(C_R,   0, 0, 8,  0, 0, 0,  0, 0, 0, 7, 1, 4);
        tbl[9]  = mk(C_LW,  0, 7, 0,  0, 0, 0,  2, 8, 1, 0, 1, 7);
        tbl[10] = mk(C_SW,  0, 7, 0,  1, 0, 0,  0, 7, 0, 8, 0, 0);
        tbl[11] = mk(C_SW,  0, 7, 0,  0, 0, 0,  0, 0, 1, 7, 1, 8);
        tbl[12] = mk(C_NOP, 0, 0, 0,  0, 0, 1,  0, 7, 0, 0, 1, 7);
        tbl[13] = mk(C_LW,  0, 9, 0,  0, 0, 0,  0, 0, 0, 7, 0, 0);
        tbl[14] = mk(C_LW,  1, 9, 0,  0, 0, 0,  0, 9, 0, 0, 0, 7);
        tbl[15] = mk(C_NOP, 0, 0, 0,  0, 0, 2,  0, 9, 1, 9, 0, 0);

        rst = 1'b1;
        drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i].cls, tbl[i].rs, tbl[i].rt, tbl[i].rd, 1'b0);
            #1;
            chk($sformatf("row%0d stall", i),       32'(stall),       32'(tbl[i].e_stall));
            chk($sformatf("row%0d fwd_a", i),       32'(fwd_a),       32'(tbl[i].e_fwd_a));
            chk($sformatf("row%0d fwd_b", i),       32'(fwd_b),       32'(tbl[i].e_fwd_b));
            chk($sformatf("row%0d ex_aluop", i),    32'(ex_aluop),    32'(tbl[i].e_ex_aluop));
            chk($sformatf("row%0d ex_dst", i),      32'(ex_dst),      32'(tbl[i].e_ex_dst));
            chk($sformatf("row%0d mem_memread", i), 32'(mem_memread), 32'(tbl[i].e_mem_memread));
            chk($sformatf("row%0d mem_dst", i),     32'(mem_dst),     32'(tbl[i].e_mem_dst));
            chk($sformatf("row%0d wb_regwrite", i), 32'(wb_regwrite), 32'(tbl[i].e_wb_regwrite));
            chk($sformatf("row%0d wb_dst", i),      32'(wb_dst),      32'(tbl[i].e_wb_dst));
        end

        // Flush on top of a live load-use hazard: stall must drop and EX must take a bubble.
        @(negedge clk);
        drive(C_LW, 5'd0, 5'd5, 5'd0, 1'b0);
        @(negedge clk);
        drive(C_R, 5'd5, 5'd0, 5'd6, 1'b0);
        #1;
        chk("flush pre stall", 32'(stall), 1);
        flush = 1'b1;
        #1;
        chk("flush stall", 32'(stall), 0);
        @(negedge clk);
        chk("flush ex_aluop", 32'(ex_aluop), 0);
        chk("flush ex_dst",   32'(ex_dst), 0);
        chk("flush ex_rs",    32'(ex_rs), 0);
        chk("flush mem_memread", 32'(mem_memread), 1);

        // Reset asserted mid-stall, away from any clock edge.
        drive(C_LW, 5'd0, 5'd5, 5'd0, 1'b0);
        @(negedge clk);
        drive(C_R, 5'd5, 5'd2, 5'd6, 1'b0);
        #1;
        chk("midrst pre stall", 32'(stall), 1);
        chk("midrst pre ex_dst", 32'(ex_dst), 5);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;

        // First edge after release latches ID normally.
        drive(C_ORI, 5'd1, 5'd3, 5'd0, 1'b0);
        @(negedge clk);
        chk("post_rst ex_aluop",   32'(ex_aluop), 3);
        chk("post_rst ex_alusrcb", 32'(ex_alusrcb), 2);
        chk("post_rst ex_dst",     32'(ex_dst), 3);
        chk("post_rst ex_rs",      32'(ex_rs), 1);
        chk("post_rst ex_rt",      32'(ex_rt), 3);
        chk("post_rst stall",      32'(stall), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
